t5_lsu: RTL and testbench

T5_LSU -- requirements
Module: t5_lsu

---
 rtl/t5_pkg.sv | 13 +
 rtl/t5_lsu_align.sv | 16 +
 rtl/t5_lsu.sv | 84 ++++++++
 tb/tb_t5_lsu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/t5_pkg.sv
// t5_pkg: shared opcodes, access-size encodings and LSU state for the t5 core
package t5_pkg;
  localparam logic [4:0] OPC_LOAD = 5'h00;
  localparam logic [4:0] OPC_STORE = 5'h08;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} size_e;
  typedef enum logic {IDLE, REQ} lsu_state_e;
  function automatic logic misaligned(size_e sz, logic [1:0] a);
    return sz == SZ_X || (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'd0);
  endfunction
  function automatic logic [3:0] lane_sel(size_e sz, logic [1:0] a);
    return sz == SZ_B ? 4'b0001 << a : sz == SZ_H ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/t5_lsu_align.sv
// t5_lsu_align: shifts the bus read word to the addressed lane and sign/zero extends it
import t5_pkg::*;
module t5_lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] dti,
  input  logic [1:0]      ofs,
  input  size_e           sz,
  input  logic            uns,
  output logic [XLEN-1:0] res
);
  logic [XLEN-1:0] sh;
  assign sh = dti >> {ofs, 3'b000};
  assign res = sz == SZ_B ? {{(XLEN-8){sh[7] & ~uns}}, sh[7:0]}
             : sz == SZ_H ? {{(XLEN-16){sh[15] & ~uns}}, sh[15:0]} : sh;
endmodule

// File: rtl/t5_lsu.sv
// t5_lsu: load/store unit issuing one data-bus cycle per memory op, with timeout and misalign traps
import t5_pkg::*;
module t5_lsu #(
  parameter int XLEN = 32,
  parameter int TMO = 255
) (
  input  logic            sclk,
  input  logic            srst_n,
  input  logic            sena,
  input  logic [6:2]      xopc,
  input  logic [14:12]    xfn3,
  input  logic [XLEN-1:0] xbpc,
  input  logic [XLEN-1:0] xdat,
  output logic [XLEN-1:0] dwb_adr,
  output logic [XLEN-1:0] dwb_dto,
  output logic [3:0]      dwb_sel,
  output logic            dwb_we,
  output logic            dwb_stb,
  input  logic            dwb_ack,
  input  logic [XLEN-1:0] dwb_dti,
  output logic [XLEN-1:0] mldt,
  output logic            mstl,
  output logic            mexc
);
  localparam logic [7:0] TLAST = 8'(TMO - 1);
  lsu_state_e st, st_nx;
  logic [7:0] cnt;
  logic [1:0] ofs;
  size_e sz, xsz;
  logic uns, mem, bad, tmo;
  logic [XLEN-1:0] ld;
  assign xsz = size_e'(xfn3[13:12]);
  assign mem = sena && (xopc == OPC_LOAD || xopc == OPC_STORE);
  assign bad = misaligned(xsz, xbpc[1:0]);
  assign tmo = cnt == TLAST;
  assign mstl = st == REQ && !dwb_ack;
  t5_lsu_align #(.XLEN(XLEN)) u_align (.dti(dwb_dti), .ofs(ofs), .sz(sz), .uns(uns), .res(ld));
  always_comb begin
    st_nx = st;
    st_nx = st == IDLE ? (mem && !bad ? REQ : IDLE) : (dwb_ack || tmo ? IDLE : REQ);
  end
  always_ff @(posedge sclk or negedge srst_n)
    if (!srst_n) st <= IDLE;
    else st <= st_nx;
  // ack is tested before the timeout so a coincident ack completes normally
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      dwb_adr <= '0;
      dwb_dto <= '0;
      dwb_sel <= '0;
      dwb_we <= 1'b0;
      dwb_stb <= 1'b0;
      mldt <= '0;
      mexc <= 1'b0;
      cnt <= '0;
      ofs <= '0;
      sz <= SZ_B;
      uns <= 1'b0;
    end else begin
      mexc <= 1'b0;
      if (st == IDLE) begin
        if (mem && bad) mexc <= 1'b1;
        else if (mem) begin
          dwb_adr <= {xbpc[XLEN-1:2], 2'b00};
          dwb_dto <= xdat;
          dwb_sel <= lane_sel(xsz, xbpc[1:0]);
          dwb_we <= xopc == OPC_STORE;
          dwb_stb <= 1'b1;
          cnt <= '0;
          ofs <= xbpc[1:0];
          sz <= xsz;
          uns <= xfn3[14];
        end
      end else if (dwb_ack) begin
        dwb_stb <= 1'b0;
        if (!dwb_we) mldt <= ld;
      end else if (tmo) begin
        dwb_stb <= 1'b0;
        mldt <= '0;
        mexc <= 1'b1;
      end else cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_t5_lsu.sv
// tb_t5_lsu: directed checks of the t5 load/store unit with a 4-cycle bus timeout
module tb_t5_lsu;
  logic sclk = 1'b0, srst_n = 1'b0, sena = 1'b0, dwb_ack = 1'b0;
  logic [6:2] xopc = 5'h04;
  logic [14:12] xfn3 = 3'b000;
  logic [31:0] xbpc = '0, xdat = '0, dwb_dti = '0;
  logic [31:0] dwb_adr, dwb_dto, mldt;
  logic [3:0] dwb_sel;
  logic dwb_we, dwb_stb, mstl, mexc;
  int errors = 0, checks = 0;
  t5_lsu #(.XLEN(32), .TMO(4)) dut (
    .sclk(sclk), .srst_n(srst_n), .sena(sena), .xopc(xopc), .xfn3(xfn3), .xbpc(xbpc), .xdat(xdat),
    .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel), .dwb_we(dwb_we), .dwb_stb(dwb_stb),
    .dwb_ack(dwb_ack), .dwb_dti(dwb_dti), .mldt(mldt), .mstl(mstl), .mexc(mexc)
  );
  always #5 sclk = ~sclk;
  task automatic tick;
    @(posedge sclk);
    #1;
  endtask
  task automatic issue(input logic [4:0] o, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    sena = 1'b1; xopc = o; xfn3 = f; xbpc = a; xdat = d;
    tick();
    sena = 1'b0; xopc = 5'h04;
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if (dwb_stb !== 1'b0 || dwb_we !== 1'b0 || dwb_sel !== 4'h0 || dwb_adr !== 32'h0 || dwb_dto !== 32'h0 ||
        mldt !== 32'h0 || mexc !== 1'b0 || mstl !== 1'b0) begin
      errors++;
      $display("FAIL reset stb=%b we=%b sel=%h adr=%h dto=%h mldt=%h mexc=%b mstl=%b, want all zero",
               dwb_stb, dwb_we, dwb_sel, dwb_adr, dwb_dto, mldt, mexc, mstl);
    end
    @(negedge sclk);
    srst_n = 1'b1;
    tick();
  endtask
  task automatic test_load_word;
    int n;
    issue(5'h00, 3'b010, 32'h100, 32'h0);
    checks++;
    if (dwb_stb !== 1'b1 || dwb_sel !== 4'hF || dwb_adr !== 32'h100 || dwb_we !== 1'b0) begin
      errors++;
      $display("FAIL lw_req stb=%b sel=%h adr=%h we=%b, want 1 f 00000100 0", dwb_stb, dwb_sel, dwb_adr, dwb_we);
    end
    n = int'(mstl);
    tick(); n += int'(mstl);
    tick(); n += int'(mstl);
    checks++;
    if (dwb_adr !== 32'h100 || dwb_sel !== 4'hF || dwb_stb !== 1'b1) begin
      errors++;
      $display("FAIL lw_hold adr=%h sel=%h stb=%b, want 00000100 f 1", dwb_adr, dwb_sel, dwb_stb);
    end
    dwb_ack = 1'b1; dwb_dti = 32'hDEADBEEF;
    #1;
    checks++;
    if (n !== 3 || mstl !== 1'b0) begin
      errors++;
      $display("FAIL lw_mstl high_cycles=%0d mstl_on_ack=%b, want 3 0", n, mstl);
    end
    tick();
    dwb_ack = 1'b0;
    checks++;
    if (mldt !== 32'hDEADBEEF || dwb_stb !== 1'b0 || mexc !== 1'b0) begin
      errors++;
      $display("FAIL lw_data mldt=%h stb=%b mexc=%b, want deadbeef 0 0", mldt, dwb_stb, mexc);
    end
  endtask
  task automatic test_byte_half;
    issue(5'h00, 3'b000, 32'h103, 32'h0);
    checks++;
    if (dwb_sel !== 4'b1000 || dwb_adr !== 32'h100) begin
      errors++;
      $display("FAIL lb_sel sel=%b adr=%h, want 1000 00000100", dwb_sel, dwb_adr);
    end
    dwb_ack = 1'b1; dwb_dti = 32'h80000000;
    tick();
    dwb_ack = 1'b0;
    checks++;
    if (mldt !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL lb_signed mldt=%h, want ffffff80", mldt);
    end
    issue(5'h00, 3'b100, 32'h103, 32'h0);
    dwb_ack = 1'b1;
    tick();
    dwb_ack = 1'b0;
    checks++;
    if (mldt !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu mldt=%h, want 00000080", mldt);
    end
    issue(5'h00, 3'b001, 32'h102, 32'h0);
    checks++;
    if (dwb_sel !== 4'b1100) begin
      errors++;
      $display("FAIL lh_sel sel=%b, want 1100", dwb_sel);
    end
    dwb_ack = 1'b1; dwb_dti = 32'h80017F00;
    tick();
    dwb_ack = 1'b0;
    checks++;
    if (mldt !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh_signed mldt=%h, want ffff8001", mldt);
    end
  endtask
  task automatic test_store_half;
    issue(5'h08, 3'b001, 32'h202, 32'h12341234);
    checks++;
    if (dwb_adr !== 32'h200 || dwb_sel !== 4'b1100 || dwb_we !== 1'b1 || dwb_dto !== 32'h12341234 || dwb_stb !== 1'b1) begin
      errors++;
      $display("FAIL sh_req adr=%h sel=%b we=%b dto=%h stb=%b, want 00000200 1100 1 12341234 1",
               dwb_adr, dwb_sel, dwb_we, dwb_dto, dwb_stb);
    end
    dwb_ack = 1'b1; dwb_dti = 32'h55555555;
    tick();
    dwb_ack = 1'b0;
    checks++;
    if (mldt !== 32'hFFFF8001 || dwb_stb !== 1'b0) begin
      errors++;
      $display("FAIL sh_done mldt=%h stb=%b, want ffff8001 0", mldt, dwb_stb);
    end
  endtask
  task automatic test_misaligned;
    issue(5'h00, 3'b010, 32'h101, 32'h0);
    checks++;
    if (dwb_stb !== 1'b0 || mexc !== 1'b1 || mstl !== 1'b0) begin
      errors++;
      $display("FAIL misalign stb=%b mexc=%b mstl=%b, want 0 1 0", dwb_stb, mexc, mstl);
    end
    tick();
    checks++;
    if (mexc !== 1'b0 || dwb_stb !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse mexc=%b stb=%b, want 0 0", mexc, dwb_stb);
    end
  endtask
  task automatic test_ack_idle;
    dwb_ack = 1'b1; dwb_dti = 32'hCAFEF00D;
    tick(); tick();
    dwb_ack = 1'b0;
    checks++;
    if (mldt !== 32'hFFFF8001 || dwb_stb !== 1'b0 || mexc !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle mldt=%h stb=%b mexc=%b, want ffff8001 0 0", mldt, dwb_stb, mexc);
    end
  endtask
  task automatic test_ack_wins;
    issue(5'h00, 3'b010, 32'h104, 32'h0);
    tick(); tick(); tick();
    dwb_ack = 1'b1; dwb_dti = 32'h11223344;
    tick();
    dwb_ack = 1'b0;
    checks++;
    if (mldt !== 32'h11223344 || mexc !== 1'b0 || dwb_stb !== 1'b0) begin
      errors++;
      $display("FAIL ack_wins mldt=%h mexc=%b stb=%b, want 11223344 0 0", mldt, mexc, dwb_stb);
    end
  endtask
  task automatic test_timeout;
    int n = 0;
    issue(5'h00, 3'b010, 32'h108, 32'h0);
    for (int i = 0; i < 10 && dwb_stb; i++) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 4 || mexc !== 1'b1 || mldt !== 32'h0 || mstl !== 1'b0) begin
      errors++;
      $display("FAIL timeout stb_cycles=%0d mexc=%b mldt=%h mstl=%b, want 4 1 00000000 0", n, mexc, mldt, mstl);
    end
    tick();
    checks++;
    if (mexc !== 1'b0 || dwb_stb !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse mexc=%b stb=%b, want 0 0", mexc, dwb_stb);
    end
  endtask
  task automatic test_reset_in_req;
    issue(5'h00, 3'b010, 32'h10C, 32'h0);
    tick();
    #2;
    srst_n = 1'b0;
    #1;
    checks++;
    if (dwb_stb !== 1'b0 || mexc !== 1'b0 || mstl !== 1'b0 || dwb_adr !== 32'h0 || dwb_sel !== 4'h0) begin
      errors++;
      $display("FAIL reset_req stb=%b mexc=%b mstl=%b adr=%h sel=%h, want 0 0 0 00000000 0",
               dwb_stb, mexc, mstl, dwb_adr, dwb_sel);
    end
    @(negedge sclk);
    srst_n = 1'b1;
    tick();
    checks++;
    if (mexc !== 1'b0 || dwb_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_release mexc=%b stb=%b, want 0 0", mexc, dwb_stb);
    end
    issue(5'h00, 3'b010, 32'h110, 32'h0);
    dwb_ack = 1'b1; dwb_dti = 32'hA5A5_5A5A;
    tick();
    dwb_ack = 1'b0;
    checks++;
    if (mldt !== 32'hA5A55A5A || dwb_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_next mldt=%h stb=%b, want a5a55a5a 0", mldt, dwb_stb);
    end
  endtask
  task automatic test_back_to_back;
    issue(5'h08, 3'b010, 32'h300, 32'hFEEDFACE);
    dwb_ack = 1'b1;
    tick();
    dwb_ack = 1'b0;
    checks++;
    if (dwb_stb !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap stb=%b, want 0", dwb_stb);
    end
    issue(5'h00, 3'b000, 32'h301, 32'h0);
    checks++;
    if (dwb_stb !== 1'b1 || dwb_we !== 1'b0 || dwb_sel !== 4'b0010 || dwb_adr !== 32'h300) begin
      errors++;
      $display("FAIL b2b_req stb=%b we=%b sel=%b adr=%h, want 1 0 0010 00000300", dwb_stb, dwb_we, dwb_sel, dwb_adr);
    end
    dwb_ack = 1'b1; dwb_dti = 32'h00007F00;
    tick();
    dwb_ack = 1'b0;
    checks++;
    if (mldt !== 32'h0000007F) begin
      errors++;
      $display("FAIL b2b_data mldt=%h, want 0000007f", mldt);
    end
  endtask
  initial begin
    test_reset();
    test_load_word();
    test_byte_half();
    test_store_half();
    test_misaligned();
    test_ack_idle();
    test_ack_wins();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
